// File: rtl/serdesphy_pll_pkg.sv
// Shared definitions for the analog PLL behavioural model: state encoding,
// default timing/trim constants and the acquisition-length helper.
`timescale 1ns/1ps
package serdesphy_pll_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } pll_state_e;

    localparam int PLL_STARTUP_CYCLES = 48;
    localparam int PLL_ACQ_BASE       = 960;
    localparam int PLL_TRIM_MIN       = 2;
    localparam int PLL_TRIM_MAX       = 13;

    // Higher charge-pump current halves the acquisition time per step.
    function automatic int unsigned pll_acq_len(input int unsigned base,
                                                input logic [1:0]  cp);
        return base >> cp;
    endfunction

endpackage

// File: rtl/serdesphy_pll_analog_model.sv
// Behavioural stand-in for the analog PLL macro: start-up, acquisition, lock,
// fault and glitch-injection timing driven by the controller's analog controls.
`timescale 1ns/1ps
module serdesphy_pll_analog_model
    import serdesphy_pll_pkg::*;
#(
    parameter int STARTUP_CYCLES = PLL_STARTUP_CYCLES,
    parameter int ACQ_BASE       = PLL_ACQ_BASE,
    parameter int TRIM_MIN       = PLL_TRIM_MIN,
    parameter int TRIM_MAX       = PLL_TRIM_MAX
)(
    input  logic       clk_ref_24m,
    input  logic       rst,
    input  logic       pll_enable,
    input  logic       pll_reset_n,
    input  logic       pll_bypass_en,
    input  logic [3:0] pll_vco_trim,
    input  logic [1:0] pll_cp_current,
    input  logic       pll_iso_n,
    input  logic       inj_cp_fault,
    input  logic       inj_glitch,
    input  logic [7:0] inj_glitch_len,
    output logic       pll_lock_raw,
    output logic       pll_vco_ok,
    output logic       pll_cp_ok,
    output logic [2:0] model_state
);

    localparam int MAXC = (STARTUP_CYCLES > ACQ_BASE) ? STARTUP_CYCLES : ACQ_BASE;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] STARTUP_LD = CW'(STARTUP_CYCLES - 1);

    pll_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_glitch;
    logic [3:0]    r_trim_prev;
    logic          r_lock, r_vco_ok, r_cp_ok;

    pll_state_e    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]    w_glitch_nxt;
    logic [31:0]   w_acq_full;
    logic [CW-1:0] w_acq_ld;
    logic          w_run, w_in_range, w_cp_good, w_good, w_trim_chg, w_active;

    assign w_run      = pll_enable & pll_reset_n & ~pll_bypass_en;
    assign w_in_range = (pll_vco_trim >= 4'(TRIM_MIN)) && (pll_vco_trim <= 4'(TRIM_MAX));
    assign w_cp_good  = ~inj_cp_fault;
    assign w_good     = w_in_range & w_cp_good;
    assign w_trim_chg = (pll_vco_trim != r_trim_prev);
    assign w_acq_full = pll_acq_len(ACQ_BASE, pll_cp_current);
    // Counter holds cycles-remaining minus one so expiry is a compare with zero.
    assign w_acq_ld   = (w_acq_full == 32'd0) ? '0 : CW'(w_acq_full - 32'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_run) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_STARTUP;
                    w_cnt_nxt   = STARTUP_LD;
                end
                ST_STARTUP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = w_good ? ST_ACQUIRE : ST_FAULT;
                        w_cnt_nxt   = w_good ? w_acq_ld : '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                ST_ACQUIRE: begin
                    if (!w_good) begin
                        w_state_nxt = ST_FAULT;
                        w_cnt_nxt   = '0;
                    end else if (w_trim_chg) begin
                        w_cnt_nxt = w_acq_ld;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!w_good) begin
                        w_state_nxt = ST_FAULT;
                    end else if (w_trim_chg) begin
                        w_state_nxt = ST_ACQUIRE;
                        w_cnt_nxt   = w_acq_ld;
                    end
                end
                ST_FAULT: begin
                    if (w_good) begin
                        w_state_nxt = ST_ACQUIRE;
                        w_cnt_nxt   = w_acq_ld;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A zero-length strobe must not cut short a glitch already in progress.
    always_comb begin
        w_glitch_nxt = r_glitch;
        if (w_state_nxt != ST_LOCKED)
            w_glitch_nxt = '0;
        else if (r_state == ST_LOCKED && inj_glitch && inj_glitch_len != 8'd0)
            w_glitch_nxt = inj_glitch_len;
        else if (r_glitch != 8'd0)
            w_glitch_nxt = r_glitch - 8'd1;
    end

    assign w_active = (w_state_nxt != ST_OFF) && (w_state_nxt != ST_STARTUP);

    always_ff @(posedge clk_ref_24m or posedge rst) begin
        if (rst) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_glitch    <= '0;
            r_trim_prev <= '0;
            r_lock      <= 1'b0;
            r_vco_ok    <= 1'b0;
            r_cp_ok     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_glitch    <= w_glitch_nxt;
            r_trim_prev <= pll_vco_trim;
            r_lock      <= (w_state_nxt == ST_LOCKED) && (w_glitch_nxt == 8'd0);
            r_vco_ok    <= w_active & w_in_range;
            r_cp_ok     <= w_active & w_cp_good;
        end
    end

    assign pll_lock_raw = r_lock   & pll_iso_n;
    assign pll_vco_ok   = r_vco_ok & pll_iso_n;
    assign pll_cp_ok    = r_cp_ok  & pll_iso_n;
    assign model_state  = r_state;

endmodule

// File: tb/tb_serdesphy_pll_analog_model.sv
// Self-checking bench: directed timing checks plus randomized control traffic,
// compared every cycle against a cycle-count reference model.
`timescale 1ns/1ps
module tb_serdesphy_pll_analog_model;

    localparam int SU   = 48;
    localparam int AB   = 960;
    localparam int TMIN = 2;
    localparam int TMAX = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, rn, byp, iso, cpf, gl;
    logic [3:0] trim;
    logic [1:0] cp;
    logic [7:0] gl_len;
    logic       lock, vco, cpok;
    logic [2:0] st;

    serdesphy_pll_analog_model dut (
        .clk_ref_24m    (clk),
        .rst            (rst),
        .pll_enable     (en),
        .pll_reset_n    (rn),
        .pll_bypass_en  (byp),
        .pll_vco_trim   (trim),
        .pll_cp_current (cp),
        .pll_iso_n      (iso),
        .inj_cp_fault   (cpf),
        .inj_glitch     (gl),
        .inj_glitch_len (gl_len),
        .pll_lock_raw   (lock),
        .pll_vco_ok     (vco),
        .pll_cp_ok      (cpok),
        .model_state    (st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference: state number plus cycles left in the current timed phase.
    int         m_st, m_left, m_g;
    logic [3:0] m_prev;
    bit         e_inr, e_cpg;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_left = 0; m_g = 0; m_prev = 4'd0; e_inr = 0; e_cpg = 0;
    endtask

    task automatic model_step();
        bit run, inr, good, tchg;
        int old, acq;
        run  = en && rn && !byp;
        inr  = (trim >= TMIN) && (trim <= TMAX);
        good = inr && !cpf;
        tchg = (trim != m_prev);
        acq  = AB >> cp;
        old  = m_st;
        if (!run) m_st = 0;
        else case (m_st)
            0: begin m_st = 1; m_left = SU; end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    if (good) begin m_st = 2; m_left = acq; end
                    else m_st = 4;
                end
            end
            2: begin
                if (!good) m_st = 4;
                else if (tchg) m_left = acq;
                else begin m_left--; if (m_left == 0) m_st = 3; end
            end
            3: begin
                if (!good) m_st = 4;
                else if (tchg) begin m_st = 2; m_left = acq; end
            end
            default: if (good) begin m_st = 2; m_left = acq; end
        endcase
        if (m_st != 3) m_g = 0;
        else if (old == 3 && gl && gl_len != 0) m_g = gl_len;
        else if (m_g > 0) m_g--;
        m_prev = trim;
        e_inr  = inr;
        e_cpg  = !cpf;
    endtask

    task automatic check_all();
        bit act;
        act = (m_st >= 2);
        chk("lock_raw",    lock, (m_st == 3 && m_g == 0 && iso) ? 1 : 0);
        chk("vco_ok",      vco,  (act && e_inr && iso) ? 1 : 0);
        chk("cp_ok",       cpok, (act && e_cpg && iso) ? 1 : 0);
        chk("model_state", st,   m_st);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    // Returns the edge at which vco_ok / lock_raw are first sampled high.
    task automatic run_to_lock(output int ev, output int el);
        ev = -1; el = -1;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (ev < 0 && vco) ev = cyc + 1;
            if (lock) begin el = cyc + 1; break; end
        end
    endtask

    int n, m, ev, el, lows, st_bad;

    initial begin
        rst = 1'b1; en = 0; rn = 0; byp = 0; iso = 0; cpf = 0; gl = 0;
        trim = 4'd0; cp = 2'd0; gl_len = 8'd0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_lock", lock, 0);
        chk("reset_state", st, 0);
        rst = 1'b0;

        // Power-up: lock at N+289 with cp=2.
        en = 1; rn = 1; trim = 4'd8; cp = 2'd2; iso = 1;
        n = cyc + 1;
        run_to_lock(ev, el);
        chk("startup_vco_rise", ev - n, 49);
        chk("startup_lock_rise", el - n, 289);

        // Trim change while locked: relock after 240 cycles.
        trim = 4'd9;
        m = cyc + 1;
        tick();
        chk("trim_chg_drop", lock, 0);
        run_to_lock(ev, el);
        chk("trim_relock", el - m, 241);

        cp = 2'd3;
        lows = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (!lock) lows++; end
        chk("cp_chg_no_drop", lows, 0);
        cp = 2'd2;

        // Glitch of length 5, then a zero-length strobe.
        gl = 1; gl_len = 8'd5;
        lows = 0; st_bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); gl = 0;
            if (!lock) lows++;
            if (st != 3'd3) st_bad++;
        end
        chk("glitch5_low_cycles", lows, 5);
        chk("glitch5_state_held", st_bad, 0);
        gl = 1; gl_len = 8'd0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin tick(); gl = 0; if (!lock) lows++; end
        chk("glitch0_low_cycles", lows, 0);

        // Out-of-range trim -> FAULT; back in range -> relock in 240.
        trim = 4'd15;
        tick(); tick();
        chk("fault_state", st, 4);
        chk("fault_vco_ok", vco, 0);
        chk("fault_cp_ok", cpok, 1);
        trim = 4'd8;
        m = cyc + 1;
        run_to_lock(ev, el);
        chk("fault_relock", el - m, 241);

        // Isolation gates outputs with zero latency.
        iso = 0;
        #1;
        chk("iso_lock", lock, 0);
        chk("iso_vco", vco, 0);
        chk("iso_cp", cpok, 0);
        chk("iso_state", st, 3);
        tick(); tick();
        iso = 1;
        tick();
        byp = 1;
        tick();
        chk("bypass_state", st, 0);
        chk("bypass_vco", vco, 0);

        // Async reset mid-acquire, then full restart.
        byp = 0;
        for (int i = 0; i < 100; i++) tick();
        chk("pre_rst_state", st, 2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_vco", vco, 0);
        chk("async_rst_cp", cpok, 0);
        chk("async_rst_state", st, 0);
        tick();
        rst = 1'b0;
        n = cyc + 1;
        run_to_lock(ev, el);
        chk("restart_vco_rise", ev - n, 49);
        chk("restart_lock_rise", el - n, 289);

        // Randomized control traffic against the reference model.
        for (int i = 0; i < 6000; i++) begin
            gl = 0;
            if (en && rn && !byp) begin
                if ($urandom_range(0, 499) == 0) begin
                    case ($urandom_range(0, 2))
                        0: en = 0;
                        1: rn = 0;
                        default: byp = 1;
                    endcase
                end
            end else if ($urandom_range(0, 19) == 0) begin
                en = 1; rn = 1; byp = 0;
            end
            if ($urandom_range(0, 199) == 0)
                trim = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(TMIN, TMAX));
            if ($urandom_range(0, 59) == 0) cp = 2'($urandom_range(0, 3));
            if (cpf ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 399) == 0)) cpf = ~cpf;
            if ($urandom_range(0, 39) == 0) begin
                gl = 1; gl_len = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 149) == 0) iso = ~iso;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
